// File: rtl/phit_operand_dispatcher_if.sv
// Phit stream into the dispatcher and the {op, inp1, inp2} lane bundle out to the PE column.
// slave = dispatcher side, master = network/PE side.
interface phit_operand_dispatcher_if #(
  parameter int phit_size = 512
);
  logic [phit_size-1:0] s_tdata;
  logic                 s_tvalid;
  logic                 s_tready;
  logic                 s_tlast;
  logic                 m_valid;
  logic                 m_ready;
  logic [1:0]           m_op;
  logic [phit_size-1:0] m_inp1;
  logic [phit_size-1:0] m_inp2;
  logic                 m_last_entry;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_ready,
    output s_tready, m_valid, m_op, m_inp1, m_inp2, m_last_entry
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_ready,
    input  s_tready, m_valid, m_op, m_inp1, m_inp2, m_last_entry
  );
endinterface

// File: rtl/phit_operand_dispatcher.sv
// Operand dispatcher: pairs each inbound phit with its RF row and config-table op, then feeds the PE column.
// Optional macro DISPATCH_STATS_EN adds the stat_phits / stat_stall counters.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | read config entry idx, skip empty entries
// STREAM | accept num_phits phits of the current entry
// DRAIN  | wait for empty pipeline, then pulse done
module phit_operand_dispatcher #(
  parameter int dwidth_double          = 64,
  parameter int SIMD_degree            = 8,
  parameter int phit_size              = 512,
  parameter int depth_RF               = 4096,
  parameter int max_depth_config_table = 256
) (
  input  logic                                      ap_clk,
  input  logic                                      ap_rst_n,
  input  logic                                      cfg_we,
  input  logic [$clog2(max_depth_config_table)-1:0] cfg_waddr,
  input  logic [26:0]                               cfg_wdata,
  input  logic [$clog2(max_depth_config_table):0]   cfg_num_entries,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err_tlast,
  output logic                                      rf_rd_en,
  output logic [$clog2(depth_RF/SIMD_degree)-1:0]   rf_rd_addr,
  input  logic [phit_size-1:0]                      rf_rd_data,
  phit_operand_dispatcher_if.slave                  bus
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                               stat_phits,
  output logic [31:0]                               stat_stall
`endif
);

  localparam int cw        = $clog2(max_depth_config_table);
  localparam int aw        = $clog2(depth_RF/SIMD_degree);
  localparam int lane_bits = dwidth_double*SIMD_degree;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t state, state_nx;

  logic [26:0]          cfg_tab [max_depth_config_table];
  logic [26:0]          entry;
  logic [cw:0]          idx, num_q;
  logic [1:0]           cur_op;
  logic [aw-1:0]        cur_base;
  logic [15:0]          cur_n, k;
  logic                 s1_valid, s1_fresh, s1_last;
  logic [1:0]           s1_op;
  logic [lane_bits-1:0] s1_data, s1_hold;
  logic                 last_tlast, any_phit;
  logic                 accept, s1_adv, pipe_empty, k_last, run_end;

  assign entry         = cfg_tab[idx[cw-1:0]];
  assign run_end       = (idx >= num_q);
  assign k_last        = (k == cur_n - 16'd1);
  assign s1_adv        = !bus.m_valid || bus.m_ready;
  assign pipe_empty    = !s1_valid && !bus.m_valid;
  assign bus.s_tready  = (state == STREAM) && (!s1_valid || s1_adv);
  assign accept        = bus.s_tvalid && bus.s_tready;
  assign rf_rd_en      = accept;
  assign rf_rd_addr    = cur_base + k[aw-1:0];
  assign busy          = (state != IDLE);

  always_ff @(posedge ap_clk) begin
    if (cfg_we && state == IDLE) cfg_tab[cfg_waddr] <= cfg_wdata;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (run_end) state_nx = DRAIN;
               else if (entry[26:11] != 16'd0) state_nx = STREAM;
      STREAM:  if (accept && k_last) state_nx = LOAD;
      DRAIN:   if (pipe_empty) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state            <= IDLE;
      done             <= 1'b0;
      err_tlast        <= 1'b0;
      idx              <= '0;
      num_q            <= '0;
      cur_op           <= '0;
      cur_base         <= '0;
      cur_n            <= '0;
      k                <= '0;
      last_tlast       <= 1'b0;
      any_phit         <= 1'b0;
      s1_valid         <= 1'b0;
      s1_fresh         <= 1'b0;
      s1_last          <= 1'b0;
      s1_op            <= '0;
      s1_data          <= '0;
      s1_hold          <= '0;
      bus.m_valid      <= 1'b0;
      bus.m_op         <= '0;
      bus.m_inp1       <= '0;
      bus.m_inp2       <= '0;
      bus.m_last_entry <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == DRAIN) && pipe_empty;

      if (state == IDLE && start) begin
        idx        <= '0;
        num_q      <= cfg_num_entries;
        err_tlast  <= 1'b0;
        last_tlast <= 1'b0;
        any_phit   <= 1'b0;
      end

      if (state == LOAD && !run_end) begin
        idx      <= idx + 1'b1;
        cur_op   <= entry[1:0];
        cur_base <= entry[10:2];
        cur_n    <= entry[26:11];
        k        <= '0;
      end

      // A phit following a tlast phit means tlast came early; a run ending without tlast is also flagged.
      if (state == LOAD && run_end && any_phit && !last_tlast) err_tlast <= 1'b1;

      if (accept) begin
        if (last_tlast) err_tlast <= 1'b1;
        k          <= k + 16'd1;
        last_tlast <= bus.s_tlast;
        any_phit   <= 1'b1;
        s1_valid   <= 1'b1;
        s1_fresh   <= 1'b1;
        s1_data    <= bus.s_tdata;
        s1_op      <= cur_op;
        s1_last    <= k_last;
      end else begin
        s1_fresh <= 1'b0;
        if (s1_adv) s1_valid <= 1'b0;
      end

      // The RF row is only on rf_rd_data the cycle after the read, so park it until s1 moves.
      if (s1_fresh) s1_hold <= rf_rd_data;

      if (s1_adv) begin
        bus.m_valid <= s1_valid;
        if (s1_valid) begin
          bus.m_op         <= s1_op;
          bus.m_inp1       <= s1_data;
          bus.m_inp2       <= s1_fresh ? rf_rd_data : s1_hold;
          bus.m_last_entry <= s1_last;
        end
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || (state == IDLE && start)) begin
      stat_phits <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && stat_phits != '1) stat_phits <= stat_phits + 32'd1;
      if (bus.m_valid && !bus.m_ready && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phit_operand_dispatcher.sv
// Testbench for phit_operand_dispatcher: directed spec scenarios plus randomized runs against a queue-based model.
module tb_phit_operand_dispatcher;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [7:0]   cfg_waddr = '0;
  logic [26:0]  cfg_wdata = '0;
  logic [8:0]   cfg_num_entries = '0;
  logic         start = 1'b0;
  logic         busy, done, err_tlast, rf_rd_en;
  logic [8:0]   rf_rd_addr;
  logic [511:0] rf_rd_data;
`ifdef DISPATCH_STATS_EN
  logic [31:0]  stat_phits, stat_stall;
`endif

  always #5 ap_clk = ~ap_clk;

  phit_operand_dispatcher_if bus ();

  phit_operand_dispatcher dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .cfg_we          (cfg_we),
    .cfg_waddr       (cfg_waddr),
    .cfg_wdata       (cfg_wdata),
    .cfg_num_entries (cfg_num_entries),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .err_tlast       (err_tlast),
    .rf_rd_en        (rf_rd_en),
    .rf_rd_addr      (rf_rd_addr),
    .rf_rd_data      (rf_rd_data),
    .bus             (bus)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_phits      (stat_phits),
    .stat_stall      (stat_stall)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // RF row memory: the row appears exactly one cycle after the strobe, garbage otherwise.
  logic [511:0] rf_mem [512];
  always @(posedge ap_clk) rf_rd_data <= rf_rd_en ? rf_mem[rf_rd_addr] : rnd512();

  typedef struct packed {
    logic [1:0]   op;
    logic [511:0] inp1;
    logic [511:0] inp2;
    logic         last;
  } beat_t;

  typedef struct {
    int op;
    int addr;
    bit last;
  } exp_t;

  int    cyc = 0;
  beat_t got_q[$];
  int    got_cyc[$];
  int    addr_q[$];
  int    acc_cyc[$];
  int    done_cnt = 0;
  beat_t prev_beat;
  bit    prev_stall = 1'b0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(negedge ap_clk) begin
    beat_t cur;
    cur = '{bus.m_op, bus.m_inp1, bus.m_inp2, bus.m_last_entry};
    if (prev_stall && ap_rst_n)
      chk("stall_hold", 512'(cur === prev_beat && bus.m_valid === 1'b1), 512'd1);
    prev_stall = ap_rst_n && bus.m_valid && !bus.m_ready;
    prev_beat  = cur;
    if (bus.m_valid && bus.m_ready) begin
      got_q.push_back(cur);
      got_cyc.push_back(cyc);
    end
    if (rf_rd_en) begin
      addr_q.push_back(int'(rf_rd_addr));
      acc_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  int m_n [256];
  int m_base [256];
  int m_op [256];
  int stall_acc;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic write_cfg(input int idx, input int n, input int base, input int op);
    cfg_we    = 1'b1;
    cfg_waddr = 8'(idx);
    cfg_wdata = {16'(n), 9'(base), 2'(op)};
    tick();
    cfg_we    = 1'b0;
    m_n[idx]    = n;
    m_base[idx] = base;
    m_op[idx]   = op;
  endtask

  // rmode: 0 = m_ready high, 1 = m_ready low for 5 cycles mid-stream, 2 = random m_ready.
  task automatic do_run(input int nent, input int tlast_idx, input int rmode, input bit gaps);
    exp_t         exp_q[$];
    logic [511:0] phit_q[$];
    exp_t         e;
    int           total, sent, rc;
    bit           acc, finished, pend, exp_err;
    for (int en = 0; en < nent; en++)
      for (int j = 0; j < m_n[en]; j++) begin
        e.op   = m_op[en];
        e.addr = (m_base[en] + j) % 512;
        e.last = (j == m_n[en] - 1);
        exp_q.push_back(e);
      end
    total = exp_q.size();
    for (int i = 0; i < total; i++) phit_q.push_back(rnd512());
    exp_err = (total > 0) && (tlast_idx != total - 1);

    got_q.delete(); got_cyc.delete(); addr_q.delete(); acc_cyc.delete();
    done_cnt = 0; stall_acc = 0;
    bus.m_ready     = 1'b1;
    cfg_num_entries = 9'(nent);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clear_on_start", err_tlast, 0);

    sent = 0; rc = 0; finished = 0; pend = 0;
    while (!finished && rc < 3000) begin
      case (rmode)
        1:       bus.m_ready = !(rc >= 6 && rc < 11);
        2:       bus.m_ready = ($urandom_range(0, 3) != 0);
        default: bus.m_ready = 1'b1;
      endcase
      if (!pend) pend = (sent < total) && (!gaps || $urandom_range(0, 2) != 0);
      bus.s_tvalid = pend;
      bus.s_tdata  = (sent < total) ? phit_q[sent] : rnd512();
      bus.s_tlast  = (sent == tlast_idx);
      @(negedge ap_clk);
      acc = bus.s_tvalid && bus.s_tready;
      if (rmode == 1 && rc >= 7 && rc < 11 && acc) stall_acc++;
      if (done) finished = 1;
      @(posedge ap_clk);
      #1;
      if (acc) begin
        sent++;
        pend = 0;
      end
      rc++;
    end
    bus.s_tvalid = 1'b0;
    bus.m_ready  = 1'b1;
    tick();
    tick();

    chk("done_seen", 512'(finished), 512'd1);
    chk("phits_accepted", sent, total);
    chk("beat_count", got_q.size(), total);
    chk("rd_count", addr_q.size(), total);
    for (int i = 0; i < total; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("beat%0d_op", i), got_q[i].op, exp_q[i].op);
        chk($sformatf("beat%0d_inp1", i), got_q[i].inp1, phit_q[i]);
        chk($sformatf("beat%0d_inp2", i), got_q[i].inp2, rf_mem[exp_q[i].addr]);
        chk($sformatf("beat%0d_last_entry", i), got_q[i].last, exp_q[i].last);
      end
      if (i < addr_q.size()) chk($sformatf("rd%0d_addr", i), addr_q[i], exp_q[i].addr);
    end
    chk("err_tlast", err_tlast, exp_err);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int nent, total, tl;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tdata  = '0;
    bus.m_ready  = 1'b1;
    for (int i = 0; i < 512; i++) rf_mem[i] = rnd512();

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_tlast, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_rf_rd_en", rf_rd_en, 0);
    ap_rst_n = 1'b1;
    tick();

    // Zero entries: done two cycles after start; config writes while busy are dropped.
    write_cfg(0, 3, 5, 2);
    cfg_num_entries = 9'd0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_busy", busy, 1);
    chk("zero_done_c1", done, 0);
    cfg_we = 1'b1; cfg_waddr = 8'd0; cfg_wdata = {16'd7, 9'd300, 2'd0};
    tick();
    cfg_we = 1'b0;
    chk("zero_done_c2", done, 0);
    tick();
    chk("zero_done_c3", done, 1);
    chk("zero_busy_end", busy, 0);
    tick();
    chk("zero_done_c4", done, 0);

    // Single entry op=2 base=5 n=3 (entry 0 must still hold this after the ignored write).
    do_run(1, 2, 0, 0);
    if (acc_cyc.size() >= 3 && got_cyc.size() >= 3) begin
      chk("latency_first", got_cyc[0] - acc_cyc[0], 2);
      chk("accept_rate", acc_cyc[2] - acc_cyc[0], 2);
      chk("beat_rate", got_cyc[2] - got_cyc[0], 2);
    end else chk("latency_samples", acc_cyc.size() + got_cyc.size(), 6);

    // RF address wrap.
    write_cfg(0, 4, 510, 1);
    do_run(1, 3, 0, 0);

    // Zero-length entry in the middle is skipped.
    write_cfg(0, 2, 40, 1);
    write_cfg(1, 0, 77, 2);
    write_cfg(2, 1, 90, 3);
    do_run(3, 2, 0, 0);

    // Back-pressure: m_ready low for 5 cycles.
    write_cfg(0, 12, 100, 0);
    do_run(1, 11, 1, 0);
    chk("stall_no_accept", stall_acc, 0);
`ifdef DISPATCH_STATS_EN
    chk("stat_stall", stat_stall, 5);
    chk("stat_phits", stat_phits, 12);
`endif

    // Early tlast flags the error but all beats still go out; next start clears it.
    write_cfg(0, 3, 200, 2);
    do_run(1, 1, 0, 0);
    do_run(1, 2, 0, 0);

    // Reset mid-stream.
    write_cfg(0, 10, 20, 3);
    cfg_num_entries = 9'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = rnd512();
      bus.s_tlast  = 1'b0;
      tick();
    end
    ap_rst_n = 1'b0;
    bus.s_tvalid = 1'b0;
    done_cnt = 0;
    tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err_tlast, 0);
    chk("mrst_m_valid", bus.m_valid, 0);
    chk("mrst_m_op", bus.m_op, 0);
    chk("mrst_m_inp1", bus.m_inp1, 0);
    chk("mrst_m_inp2", bus.m_inp2, 0);
    chk("mrst_m_last", bus.m_last_entry, 0);
    chk("mrst_s_tready", bus.s_tready, 0);
    chk("mrst_rf_rd_en", rf_rd_en, 0);
    chk("mrst_rf_rd_addr", rf_rd_addr, 0);
    ap_rst_n = 1'b1;
    repeat (6) tick();
    chk("mrst_no_done", done_cnt, 0);
    do_run(1, 9, 0, 0);

    // Randomized runs with gaps and random back-pressure.
    for (int r = 0; r < 8; r++) begin
      nent  = $urandom_range(1, 4);
      total = 0;
      for (int en = 0; en < nent; en++) begin
        write_cfg(en, $urandom_range(0, 5), $urandom_range(0, 511), $urandom_range(0, 3));
        total += m_n[en];
      end
      if ($urandom_range(0, 3) == 0) tl = (total > 0) ? $urandom_range(0, total - 1) : -1;
      else tl = total - 1;
      do_run(nent, tl, 2, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
